// File: rtl/gas_pkg.sv
// gas_pkg: shared constants and run-state encoding for the gas feature framer
package gas_pkg;
  localparam int N = 128;
  localparam int B = 4;
  localparam int M = 40;
  localparam int C = 6;
  localparam int KW = $clog2(C);
  localparam int LAT = N + M;
  localparam int FW = $clog2(N);
  localparam int RW = $clog2(LAT);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} run_state_t;
endpackage

// File: rtl/gas_frame_buffer.sv
// gas_frame_buffer: shifts feature beats into a frame and flags complete or malformed frames
module gas_frame_buffer
  import gas_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           feat_valid,
  output logic           feat_ready,
  input  logic [B-1:0]   feat_data,
  input  logic           feat_last,
  input  logic           take,
  output logic [B*N-1:0] frame,
  output logic           full,
  output logic           frame_err
);
  logic [FW-1:0] fcnt;
  logic hs, at_end;
  assign feat_ready = !full;
  assign hs = feat_valid && !full;
  assign at_end = fcnt == FW'(N - 1);
  // a frame is well formed only when feat_last and the final slot coincide
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frame <= '0;
      fcnt <= '0;
      full <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= hs && (feat_last != at_end);
      if (hs) begin
        frame <= {frame[B*(N-1)-1:0], feat_data};
        fcnt <= (feat_last || at_end) ? '0 : fcnt + 1'b1;
      end
      full <= take ? 1'b0 : (full || (hs && feat_last && at_end));
    end
endmodule

// File: rtl/gas_feature_framer.sv
// gas_feature_framer: frames features for the classifier, sequences its reset and returns the class
module gas_feature_framer
  import gas_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           feat_valid,
  output logic           feat_ready,
  input  logic [B-1:0]   feat_data,
  input  logic           feat_last,
  output logic [B*N-1:0] data,
  output logic           tnn_rst,
  input  logic [KW-1:0]  klass,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [KW-1:0]  res_klass,
  output logic           frame_err
);
  run_state_t state, nxt;
  logic [RW-1:0] rcnt;
  logic [B*N-1:0] frame;
  logic full, take, last_run;
  assign take = state == LOAD;
  assign last_run = rcnt == RW'(LAT - 1);
  assign tnn_rst = state != RUN;
  assign res_valid = state == DONE;
  gas_frame_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .feat_valid(feat_valid),
    .feat_ready(feat_ready),
    .feat_data(feat_data),
    .feat_last(feat_last),
    .take(take),
    .frame(frame),
    .full(full),
    .frame_err(frame_err)
  );
  always_comb
    nxt = state == IDLE ? (full ? LOAD : IDLE) :
          state == LOAD ? RUN :
          state == RUN  ? (last_run ? DONE : RUN) :
          res_ready     ? (full ? LOAD : IDLE) : DONE;
  // klass is sampled on the edge that ends the final RUN cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rcnt <= '0;
      data <= '0;
      res_klass <= '0;
    end else begin
      state <= nxt;
      if (take) begin
        data <= frame;
        rcnt <= '0;
      end
      if (state == RUN && !last_run) rcnt <= rcnt + 1'b1;
      if (state == RUN && last_run) res_klass <= klass;
    end
endmodule
